// File: rtl/pool_pkg.sv
// Shared pooling types and default sizes, used by the pooling top, regfile and drain.
package pool_pkg;
  localparam int POOL_DATA_W   = 8;
  localparam int POOL_RF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;
endpackage

// File: rtl/pool_skid_buf.sv
// Two-entry FIFO of {word, last}; same-cycle push+pop keeps occupancy and order.
module pool_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_word,
  input  logic         push_last,
  input  logic         pop,
  output logic [W-1:0] head_word,
  output logic         head_last,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] word_q [2];
  logic [1:0]   last_q;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_word = word_q[rd_ptr];
  assign head_last = last_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q[0] <= '0;
      word_q[1] <= '0;
      last_q    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (do_push) begin
        word_q[wr_ptr] <= push_word;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= !wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pool_drain.sv
// Streams regfile words 0..num_words-1 to a valid/ready sink; first m_valid 2 cycles after start,
// 1 word/cycle, stalls via 2-entry credit. POOL_DRAIN_RELU_EN fuses ReLU onto m_data.
module pool_drain
  import pool_pkg::*;
#(
  parameter  int DATA_WIDTH = POOL_DATA_W,
  parameter  int DEPTH      = POOL_RF_DEPTH,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_words,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  drain_state_t          state;
  logic [CNT_W-1:0]      total;
  logic [CNT_W-1:0]      issued;
  logic [CNT_W-1:0]      req_words;
  logic                  pend;
  logic                  pend_last;
  logic                  accept;
  logic                  issue;
  logic                  issue_last;
  logic                  pop;
  logic [1:0]            occ;
  logic [1:0]            credit_used;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head_word;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] egress;

  assign req_words   = (num_words > DEPTH_CNT) ? DEPTH_CNT : num_words;
  assign accept      = (state == IDLE) && start && !rst;
  assign pop         = m_valid && m_ready;
  // A word leaving this cycle frees its slot in time for a read issued now.
  assign credit_used = occ + {1'b0, pend} - {1'b0, pop};

  // The first read goes out in the start cycle itself so data lands 2 cycles after start.
  always_comb begin
    issue      = 1'b0;
    issue_last = 1'b0;
    if (!rst) begin
      if (accept && (req_words != '0)) begin
        issue      = 1'b1;
        issue_last = (req_words == CNT_W'(1));
      end else if ((state == READ) && (issued != total) && (credit_used < 2'd2)
                   && !(full && !pop)) begin
        issue      = 1'b1;
        issue_last = ((issued + CNT_W'(1)) == total);
      end
    end
  end

  assign rd_en = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      total     <= '0;
      issued    <= '0;
      rd_addr   <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue_last;
      done      <= 1'b0;
      if (issue) begin
        issued  <= issued + CNT_W'(1);
        rd_addr <= issue_last ? '0 : rd_addr + ADDR_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            total <= req_words;
            busy  <= 1'b1;
            if (req_words == '0) state <= DONE;
            else if (issue_last)  state <= FLUSH;
            else                  state <= READ;
          end
        end
        READ: begin
          if (issue_last) state <= FLUSH;
        end
        FLUSH: begin
          if (!pend && (occ == {1'b0, pop})) state <= DONE;
        end
        DONE: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          issued <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pool_skid_buf #(.W(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (pend),
    .push_word (rd_data),
    .push_last (pend_last),
    .pop       (pop),
    .head_word (head_word),
    .head_last (head_last),
    .count     (occ),
    .full      (full),
    .empty     (empty)
  );

`ifdef POOL_DRAIN_RELU_EN
  assign egress = head_word[DATA_WIDTH-1] ? '0 : head_word;
`else
  assign egress = head_word;
`endif

  assign m_valid = !empty;
  assign m_data  = m_valid ? egress : '0;
  assign m_last  = m_valid && head_last;
endmodule
